// File: rtl/timer_mode_mux.sv
// Registered period-word selector for the timer core. Select changes wait for a
// safe boundary unless forced, so a running count never sees a mid-period change.
module timer_mode_mux #(
  parameter int WIDTH       = 25,
  parameter int NUM_IN      = 4,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_SEL = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel_req,
  input  logic                    sel_valid,
  input  logic                    force_now,
  input  logic                    boundary,
  output logic [WIDTH-1:0]        out,
  output logic [SEL_W-1:0]        active_sel,
  output logic                    pending,
  output logic                    switched,
  output logic                    sel_err
);

  // state | meaning
  // IDLE  | no deferred request
  // WAIT  | pend_sel holds a request waiting for boundary
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  state_t           state;
  logic [SEL_W-1:0] pend_sel;
  logic [WIDTH-1:0] sel_word;
  logic             req_bad;

  assign req_bad = {1'b0, sel_req} >= NUM_IN_W;
  assign pending = (state == WAIT);

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (active_sel == SEL_W'(i)) sel_word = in_bus[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_sel   <= '0;
      active_sel <= SEL_W'(DEFAULT_SEL);
      out        <= '0;
      switched   <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      out      <= sel_word;
      switched <= 1'b0;
      sel_err  <= 1'b0;
      if (sel_valid && req_bad) begin
        sel_err <= 1'b1;
      end else if (sel_valid && (force_now || boundary)) begin
        // Immediate apply also discards any older deferred request.
        active_sel <= sel_req;
        state      <= IDLE;
        switched   <= (sel_req != active_sel);
      end else if (sel_valid) begin
        pend_sel <= sel_req;
        state    <= WAIT;
      end else if (boundary && state == WAIT) begin
        active_sel <= pend_sel;
        state      <= IDLE;
        switched   <= (pend_sel != active_sel);
      end
    end
  end

endmodule

// File: tb/tb_timer_mode_mux.sv
// Bench for timer_mode_mux: directed scenarios plus randomized traffic checked
// against a behavioural model of the select rules.
module tb_timer_mode_mux;

  localparam int W = 25;
  localparam int N = 4;
  localparam int SW = 3;

  logic          clk = 0;
  logic          reset;
  logic [N*W-1:0] in_bus;
  logic [SW-1:0] sel_req;
  logic          sel_valid, force_now, boundary;
  logic [W-1:0]  out;
  logic [SW-1:0] active_sel;
  logic          pending, switched, sel_err;

  int tests_run = 0;
  int fails = 0;

  logic [W-1:0]  m_out;
  logic [SW-1:0] m_active, m_pend_sel;
  logic          m_pend, m_sw, m_err;

  timer_mode_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .DEFAULT_SEL(0)) dut (
    .clk(clk), .reset(reset), .in_bus(in_bus), .sel_req(sel_req),
    .sel_valid(sel_valid), .force_now(force_now), .boundary(boundary),
    .out(out), .active_sel(active_sel), .pending(pending),
    .switched(switched), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model applies the select rules to the inputs seen at the edge.
  task automatic tick();
    logic [SW-1:0] na, nps;
    logic np;
    @(posedge clk);
    na = m_active; np = m_pend; nps = m_pend_sel;
    if (reset) begin
      m_out = '0; m_active = '0; m_pend = 0; m_sw = 0; m_err = 0;
    end else begin
      m_out = in_bus[m_active*W +: W];
      m_err = 0;
      if (sel_valid && int'(sel_req) >= N) m_err = 1;
      else if (sel_valid && (force_now || boundary)) begin na = sel_req; np = 0; end
      else if (sel_valid) begin np = 1; nps = sel_req; end
      else if (boundary && m_pend) begin na = m_pend_sel; np = 0; end
      m_sw = (na != m_active);
      m_active = na; m_pend = np; m_pend_sel = nps;
    end
    #1;
    sel_valid = 0; force_now = 0; boundary = 0;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    in_bus[i*W +: W] = v;
  endtask

  task automatic test_reset();
    set_word(0, 180); set_word(1, 500); set_word(2, 900); set_word(3, 100000);
    reset = 1;
    tick(); tick();
    tests_run++; if (out !== 0) begin fails++; $display("FAIL reset_out got %0d exp 0", out); end
    tests_run++; if (active_sel !== 0) begin fails++; $display("FAIL reset_active got %0d exp 0", active_sel); end
    tests_run++; if (pending !== 0 || switched !== 0 || sel_err !== 0) begin fails++;
      $display("FAIL reset_flags got p%0d s%0d e%0d exp 0 0 0", pending, switched, sel_err); end
    reset = 0;
    tick();
    tests_run++; if (out !== 180) begin fails++; $display("FAIL reset_release_out got %0d exp 180", out); end
  endtask

  task automatic test_deferred();
    sel_req = 2; sel_valid = 1;
    tick();
    tests_run++; if (pending !== 1 || active_sel !== 0) begin fails++;
      $display("FAIL defer_req got p%0d a%0d exp p1 a0", pending, active_sel); end
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++; if (out !== 180 || pending !== 1) begin fails++;
        $display("FAIL defer_hold got out%0d p%0d exp out180 p1", out, pending); end
    end
    boundary = 1;
    tick();
    tests_run++; if (active_sel !== 2 || pending !== 0 || switched !== 1) begin fails++;
      $display("FAIL defer_switch got a%0d p%0d s%0d exp a2 p0 s1", active_sel, pending, switched); end
    tick();
    tests_run++; if (out !== 900 || switched !== 0) begin fails++;
      $display("FAIL defer_out got out%0d s%0d exp out900 s0", out, switched); end
  endtask

  task automatic test_overwrite();
    sel_req = 1; sel_valid = 1; tick();
    sel_req = 3; sel_valid = 1; tick();
    boundary = 1; tick();
    tests_run++; if (active_sel !== 3) begin fails++; $display("FAIL overwrite_active got %0d exp 3", active_sel); end
    tick();
    tests_run++; if (out !== 100000) begin fails++; $display("FAIL overwrite_out got %0d exp 100000", out); end
    sel_req = 1; sel_valid = 1; boundary = 1; tick();
    tests_run++; if (active_sel !== 1 || pending !== 0) begin fails++;
      $display("FAIL same_cycle got a%0d p%0d exp a1 p0", active_sel, pending); end
    tick();
    tests_run++; if (out !== 500) begin fails++; $display("FAIL same_cycle_out got %0d exp 500", out); end
  endtask

  task automatic test_force();
    sel_req = 2; sel_valid = 1; tick();
    tests_run++; if (pending !== 1) begin fails++; $display("FAIL force_pre got p%0d exp p1", pending); end
    sel_req = 0; sel_valid = 1; force_now = 1; tick();
    tests_run++; if (active_sel !== 0 || pending !== 0) begin fails++;
      $display("FAIL force_apply got a%0d p%0d exp a0 p0", active_sel, pending); end
    tick();
    boundary = 1; tick();
    tests_run++; if (active_sel !== 0 || switched !== 0 || out !== 180) begin fails++;
      $display("FAIL force_boundary got a%0d s%0d out%0d exp a0 s0 out180", active_sel, switched, out); end
  endtask

  task automatic test_error_and_reset();
    sel_req = 2; sel_valid = 1; tick();
    sel_req = 5; sel_valid = 1; force_now = 1; tick();
    tests_run++; if (sel_err !== 1 || active_sel !== 0 || pending !== 1) begin fails++;
      $display("FAIL err_pulse got e%0d a%0d p%0d exp e1 a0 p1", sel_err, active_sel, pending); end
    tick();
    tests_run++; if (sel_err !== 0) begin fails++; $display("FAIL err_width got %0d exp 0", sel_err); end
    reset = 1; boundary = 1; tick();
    tests_run++; if (pending !== 0 || active_sel !== 0 || out !== 0) begin fails++;
      $display("FAIL reset_mid_wait got p%0d a%0d out%0d exp 0 0 0", pending, active_sel, out); end
    reset = 0; tick();
  endtask

  task automatic test_live_and_same();
    logic [W-1:0] vals [3];
    vals[0] = 231234; vals[1] = 9902193; vals[2] = 33554431;
    sel_req = 1; sel_valid = 1; force_now = 1; tick();
    for (int k = 0; k < 3; k++) begin
      set_word(1, vals[k]); tick();
      tests_run++; if (out !== vals[k]) begin fails++; $display("FAIL live_out got %0d exp %0d", out, vals[k]); end
    end
    sel_req = 1; sel_valid = 1; tick();
    tests_run++; if (pending !== 1) begin fails++; $display("FAIL same_req_pend got %0d exp 1", pending); end
    boundary = 1; tick();
    tests_run++; if (pending !== 0 || switched !== 0 || active_sel !== 1) begin fails++;
      $display("FAIL same_req_clear got p%0d s%0d a%0d exp p0 s0 a1", pending, switched, active_sel); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) set_word(i, W'($urandom));
      sel_req   = SW'($urandom_range(0, 7));
      sel_valid = ($urandom_range(0, 9) < 3);
      force_now = ($urandom_range(0, 9) < 2);
      boundary  = ($urandom_range(0, 9) < 2);
      reset     = ($urandom_range(0, 49) == 0);
      tick();
      reset = 0;
      tests_run++;
      if (out !== m_out || active_sel !== m_active || pending !== m_pend ||
          switched !== m_sw || sel_err !== m_err) begin
        fails++;
        $display("FAIL random c%0d got out%0d a%0d p%0d s%0d e%0d exp out%0d a%0d p%0d s%0d e%0d",
                 c, out, active_sel, pending, switched, sel_err, m_out, m_active, m_pend, m_sw, m_err);
      end
    end
  endtask

  initial begin
    reset = 1; in_bus = '0; sel_req = '0; sel_valid = 0; force_now = 0; boundary = 0;
    m_out = '0; m_active = '0; m_pend_sel = '0; m_pend = 0; m_sw = 0; m_err = 0;
    test_reset();
    test_deferred();
    test_overwrite();
    test_force();
    test_error_and_reset();
    test_live_and_same();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
